mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_pkg.sv | 18 +
 rtl/mem_stage_if.sv | 14 +
 rtl/mem_wb_latch.sv | 41 ++++
 rtl/mem_stage.sv | 123 ++++++++++++
 tb/tb_mem_stage.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
// Holds the FSM state enum, control-bit indices and the default access timeout.
package mem_stage_pkg;

    localparam int unsigned TimeoutCycDefault = 16;

    // Bit positions inside ctlwb_in / ctlm_in
    localparam int unsigned CtlWbRegWrite = 1;
    localparam int unsigned CtlWbMemToReg = 0;
    localparam int unsigned CtlMMemRead   = 1;
    localparam int unsigned CtlMMemWrite  = 0;

    typedef enum logic {
        StIdle,
        StAccess
    } state_e;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge port between the MEM stage and the data memory.
interface mem_stage_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);

endinterface

// File: rtl/mem_wb_latch.sv
// MEM/WB pipeline register: loads a result bundle, optionally suppressing writeback,
// and captures read data only when enabled. Drops valid on any non-load edge.
module mem_wb_latch (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clr_wb,
    input  logic        rd_en,
    input  logic        valid_d,
    input  logic [1:0]  ctlwb_d,
    input  logic [31:0] alu_result_d,
    input  logic [31:0] rdata_d,
    input  logic [4:0]  muxout_d,
    output logic        valid_out,
    output logic [1:0]  ctlwb_out,
    output logic [31:0] read_data_out,
    output logic [31:0] alu_result_out,
    output logic [4:0]  muxout_out
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out      <= 1'b0;
            ctlwb_out      <= 2'b00;
            read_data_out  <= 32'h0;
            alu_result_out <= 32'h0;
            muxout_out     <= 5'h0;
        end else begin
            valid_out <= load & valid_d;
            if (load) begin
                ctlwb_out      <= clr_wb ? 2'b00 : ctlwb_d;
                alu_result_out <= alu_result_d;
                muxout_out     <= muxout_d;
            end
            if (rd_en) begin
                read_data_out <= rdata_d;
            end
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-memory accesses with a bounded ack wait,
// stalls upstream while waiting, resolves branches and feeds the MEM/WB register.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TimeoutCycDefault
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_in,
    input  logic [1:0]         ctlwb_in,
    input  logic [1:0]         ctlm_in,
    input  logic               branch_in,
    input  logic               alu_zero_in,
    input  logic [31:0]        adder_in,
    input  logic [31:0]        alu_result_in,
    input  logic [31:0]        rdata2_in,
    input  logic [4:0]         muxout_in,
    mem_stage_if.master        dmem,
    output logic               stall,
    output logic               pcsrc,
    output logic [31:0]        branch_target,
    output logic               valid_out,
    output logic [1:0]         ctlwb_out,
    output logic [31:0]        read_data_out,
    output logic [31:0]        alu_result_out,
    output logic [4:0]         muxout_out,
    output logic               err_out
);

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic        req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        err_q;

    logic memop;
    logic in_access;
    logic done;
    logic timeout;
    logic lat_load;
    logic lat_valid;
    logic lat_rd_en;

    assign memop     = valid_in & (ctlm_in[CtlMMemRead] | ctlm_in[CtlMMemWrite]);
    assign in_access = (state_q == StAccess);
    assign done      = in_access & dmem.ack;
    // An ack in the last allowed cycle completes normally, so timeout excludes it
    assign timeout   = in_access & ~dmem.ack & (cnt_q == 8'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 8'h0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (memop) begin
                        state_q <= StAccess;
                        req_q   <= 1'b1;
                        we_q    <= ctlm_in[CtlMMemWrite];
                        addr_q  <= alu_result_in;
                        wdata_q <= rdata2_in;
                        cnt_q   <= 8'h0;
                    end
                end
                StAccess: begin
                    if (done || timeout) begin
                        state_q <= StIdle;
                        req_q   <= 1'b0;
                        if (timeout) begin
                            err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign dmem.req   = req_q;
    assign dmem.we    = we_q;
    assign dmem.addr  = addr_q;
    assign dmem.wdata = wdata_q;
    assign err_out    = err_q;

    // Combinational outputs are forced low while reset is held
    assign stall = rst_n & ((~in_access & memop) | (in_access & ~dmem.ack & ~timeout));
    assign pcsrc = rst_n & valid_in & branch_in & alu_zero_in;
    assign branch_target = rst_n ? adder_in : 32'h0;

    assign lat_load  = (~in_access & ~memop) | done | timeout;
    assign lat_valid = in_access | valid_in;
    assign lat_rd_en = done & ~we_q;

    mem_wb_latch u_mem_wb_latch (
        .clk            (clk),
        .rst_n          (rst_n),
        .load           (lat_load),
        .clr_wb         (timeout),
        .rd_en          (lat_rd_en),
        .valid_d        (lat_valid),
        .ctlwb_d        (ctlwb_in),
        .alu_result_d   (alu_result_in),
        .rdata_d        (dmem.rdata),
        .muxout_d       (muxout_in),
        .valid_out      (valid_out),
        .ctlwb_out      (ctlwb_out),
        .read_data_out  (read_data_out),
        .alu_result_out (alu_result_out),
        .muxout_out     (muxout_out)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Randomized scoreboard bench for mem_stage: a driver predicts results, a memory
// responder acks with chosen latencies, and a monitor checks MEM/WB and dmem traffic.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in;
    logic [1:0]  ctlwb_in;
    logic [1:0]  ctlm_in;
    logic        branch_in;
    logic        alu_zero_in;
    logic [31:0] adder_in;
    logic [31:0] alu_result_in;
    logic [31:0] rdata2_in;
    logic [4:0]  muxout_in;
    logic        stall;
    logic        pcsrc;
    logic [31:0] branch_target;
    logic        valid_out;
    logic [1:0]  ctlwb_out;
    logic [31:0] read_data_out;
    logic [31:0] alu_result_out;
    logic [4:0]  muxout_out;
    logic        err_out;

    mem_stage_if dmem ();

    mem_stage #(.TIMEOUT_CYC(TO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_in       (valid_in),
        .ctlwb_in       (ctlwb_in),
        .ctlm_in        (ctlm_in),
        .branch_in      (branch_in),
        .alu_zero_in    (alu_zero_in),
        .adder_in       (adder_in),
        .alu_result_in  (alu_result_in),
        .rdata2_in      (rdata2_in),
        .muxout_in      (muxout_in),
        .dmem           (dmem),
        .stall          (stall),
        .pcsrc          (pcsrc),
        .branch_target  (branch_target),
        .valid_out      (valid_out),
        .ctlwb_out      (ctlwb_out),
        .read_data_out  (read_data_out),
        .alu_result_out (alu_result_out),
        .muxout_out     (muxout_out),
        .err_out        (err_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ctlwb;
        logic [31:0] alu;
        logic [4:0]  mux;
        logic [31:0] rd;
        logic        err;
    } wb_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } rq_t;

    typedef struct {
        int          lat;
        logic [31:0] rdata;
    } rsp_t;

    wb_t  wb_q[$];
    rq_t  rq_q[$];
    rsp_t rsp_q[$];

    int          checks = 0;
    int          errors = 0;
    logic [31:0] rd_model = 32'h0;
    logic        err_model = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    // Memory responder: ack in access cycle 'lat' (0 = first ACCESS cycle); noise while idle
    initial begin
        int   k;
        bit   in_acc;
        rsp_t cur;
        in_acc = 1'b0;
        k = 0;
        cur.lat = 1000;
        cur.rdata = 32'h0;
        dmem.ack = 1'b0;
        dmem.rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (!dmem.req) begin
                in_acc = 1'b0;
                dmem.ack = 1'($urandom_range(0, 1));
                dmem.rdata = $urandom;
            end else begin
                if (!in_acc) begin
                    in_acc = 1'b1;
                    k = 0;
                    if (rsp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_dmem_req actual=1 required=0");
                        cur.lat = 1000;
                    end else begin
                        cur = rsp_q.pop_front();
                    end
                end else begin
                    k++;
                end
                dmem.ack = (k == cur.lat);
                dmem.rdata = (k == cur.lat) ? cur.rdata : $urandom;
            end
        end
    end

    // Monitor: checks each MEM/WB result and each dmem request against the queues
    logic req_prev = 1'b0;
    rq_t  held_rq;
    always @(negedge clk) begin
        if (rst_n) begin
            if (dmem.req && !req_prev) begin
                if (rq_q.size() == 0) begin
                    check("dmem_req_unexpected", 32'(dmem.req), 32'h0);
                end else begin
                    rq_t r;
                    r = rq_q.pop_front();
                    held_rq <= r;
                    check("dmem_we", 32'(dmem.we), 32'(r.we));
                    check("dmem_addr", dmem.addr, r.addr);
                    check("dmem_wdata", dmem.wdata, r.wdata);
                end
            end else if (dmem.req) begin
                check("dmem_addr_hold", dmem.addr, held_rq.addr);
                check("dmem_we_hold", 32'(dmem.we), 32'(held_rq.we));
            end
            if (valid_out) begin
                if (wb_q.size() == 0) begin
                    check("valid_out_unexpected", 32'(valid_out), 32'h0);
                end else begin
                    wb_t e;
                    e = wb_q.pop_front();
                    check("ctlwb_out", 32'(ctlwb_out), 32'(e.ctlwb));
                    check("alu_result_out", alu_result_out, e.alu);
                    check("muxout_out", 32'(muxout_out), 32'(e.mux));
                    check("read_data_out", read_data_out, e.rd);
                    check("err_out", 32'(err_out), 32'(e.err));
                end
            end
        end
        req_prev <= dmem.req;
    end

    // Present one EX/MEM instruction; called at posedge+1, returns at posedge+1 after it retires
    task automatic issue(input logic v, input logic [1:0] wb, input logic [1:0] m,
                         input logic [31:0] alu, input logic [31:0] d2, input logic [4:0] mux,
                         input logic br, input logic z, input logic [31:0] adder,
                         input int lat, input logic [31:0] rdata);
        bit   memop;
        int   exp_stall;
        int   n;
        wb_t  e;
        rq_t  r;
        rsp_t s;
        valid_in = v;
        ctlwb_in = wb;
        ctlm_in = m;
        alu_result_in = alu;
        rdata2_in = d2;
        muxout_in = mux;
        branch_in = br;
        alu_zero_in = z;
        adder_in = adder;
        memop = v && (m != 2'b00);
        e.ctlwb = wb;
        e.alu = alu;
        e.mux = mux;
        e.rd = rd_model;
        e.err = err_model;
        if (!memop) begin
            exp_stall = 0;
            if (v) wb_q.push_back(e);
        end else begin
            r.we = m[0];
            r.addr = alu;
            r.wdata = d2;
            rq_q.push_back(r);
            s.lat = lat;
            s.rdata = rdata;
            rsp_q.push_back(s);
            if (lat <= int'(TO) - 1) begin
                exp_stall = 1 + lat;
                if (!m[0]) rd_model = rdata;
                e.rd = rd_model;
            end else begin
                exp_stall = int'(TO);
                err_model = 1'b1;
                e.ctlwb = 2'b00;
                e.err = 1'b1;
            end
            wb_q.push_back(e);
        end
        n = 0;
        @(negedge clk);
        check("pcsrc", 32'(pcsrc), 32'(v & br & z));
        check("branch_target", branch_target, adder);
        while (stall && n <= int'(TO) + 4) begin
            n++;
            @(negedge clk);
        end
        check("stall_cycles", 32'(n), 32'(exp_stall));
        @(posedge clk);
        #1;
    endtask

    task automatic random_issue();
        int sel;
        int lat;
        sel = $urandom_range(0, 9);
        if (sel < 6) lat = $urandom_range(0, 4);
        else if (sel == 6) lat = int'(TO) - 1;
        else if (sel == 7) lat = int'(TO) - 2;
        else if (sel == 8) lat = int'(TO);
        else lat = 255;
        issue(1'($urandom_range(0, 7) != 0), 2'($urandom), 2'($urandom), $urandom, $urandom,
              5'($urandom), 1'($urandom), 1'($urandom), $urandom, lat, $urandom);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        valid_in = 1'b1;
        ctlwb_in = 2'b11;
        ctlm_in = 2'b10;
        branch_in = 1'b1;
        alu_zero_in = 1'b1;
        adder_in = 32'h40;
        alu_result_in = 32'h100;
        rdata2_in = 32'h1;
        muxout_in = 5'd7;
        #3;
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_pcsrc", 32'(pcsrc), 32'h0);
        check("rst_branch_target", branch_target, 32'h0);
        check("rst_valid_out", 32'(valid_out), 32'h0);
        check("rst_dmem_req", 32'(dmem.req), 32'h0);
        check("rst_err_out", 32'(err_out), 32'h0);
        check("rst_read_data", read_data_out, 32'h0);
        repeat (2) @(posedge clk);
        valid_in = 1'b0;
        ctlm_in = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed: ALU op, branches, load, store, read+write, ack at limit, timeout
        issue(1'b1, 2'b10, 2'b00, 32'h5, 32'h0, 5'd3, 1'b0, 1'b0, 32'h0, 0, 32'h0);
        issue(1'b1, 2'b00, 2'b00, 32'h8, 32'h0, 5'd1, 1'b1, 1'b1, 32'h40, 0, 32'h0);
        issue(1'b1, 2'b00, 2'b00, 32'h8, 32'h0, 5'd1, 1'b1, 1'b0, 32'h40, 0, 32'h0);
        issue(1'b1, 2'b11, 2'b10, 32'h100, 32'h0, 5'd5, 1'b0, 1'b0, 32'h0, 3, 32'hDEADBEEF);
        issue(1'b1, 2'b00, 2'b01, 32'h104, 32'h1234, 5'd0, 1'b0, 1'b0, 32'h0, 1, 32'h0);
        issue(1'b1, 2'b00, 2'b11, 32'h108, 32'h55AA, 5'd0, 1'b0, 1'b0, 32'h0, 2, 32'h1111);
        issue(1'b1, 2'b11, 2'b10, 32'h10C, 32'h0, 5'd9, 1'b0, 1'b0, 32'h0, int'(TO) - 1,
              32'hCAFE0001);
        issue(1'b1, 2'b11, 2'b10, 32'h110, 32'h0, 5'd4, 1'b0, 1'b0, 32'h0, 255, 32'h0);
        issue(1'b1, 2'b10, 2'b00, 32'h6, 32'h0, 5'd2, 1'b0, 1'b0, 32'h0, 0, 32'h0);

        for (int i = 0; i < 150; i++) random_issue();

        // Reset asserted mid-access, away from any clock edge
        begin
            rq_t r;
            rsp_t s;
            valid_in = 1'b1;
            ctlm_in = 2'b10;
            alu_result_in = 32'h200;
            r.we = 1'b0;
            r.addr = 32'h200;
            r.wdata = rdata2_in;
            rq_q.push_back(r);
            s.lat = 255;
            s.rdata = 32'h0;
            rsp_q.push_back(s);
        end
        repeat (4) @(posedge clk);
        #3;
        check("pre_rst_dmem_req", 32'(dmem.req), 32'h1);
        check("pre_rst_err_out", 32'(err_out), 32'h1);
        rst_n = 1'b0;
        #1;
        check("midrst_dmem_req", 32'(dmem.req), 32'h0);
        check("midrst_stall", 32'(stall), 32'h0);
        check("midrst_err_out", 32'(err_out), 32'h0);
        check("midrst_valid_out", 32'(valid_out), 32'h0);
        check("midrst_ctlwb_out", 32'(ctlwb_out), 32'h0);
        check("midrst_read_data", read_data_out, 32'h0);
        check("midrst_alu_result", alu_result_out, 32'h0);
        check("midrst_muxout", 32'(muxout_out), 32'h0);
        check("midrst_dmem_addr", dmem.addr, 32'h0);
        check("midrst_dmem_we", 32'(dmem.we), 32'h0);
        check("midrst_pcsrc", 32'(pcsrc), 32'h0);
        rd_model = 32'h0;
        err_model = 1'b0;
        valid_in = 1'b0;
        ctlm_in = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 30; i++) random_issue();

        valid_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("wb_queue_drained", 32'(wb_q.size()), 32'h0);
        check("rq_queue_drained", 32'(rq_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
